dat_init_sequencer: RTL and testbench

- Bus initiator that fills the DAT (MMU task RAM) with a known mapping, then reads it back to verify it.
- Runs after reset and before the MMU is enabled, or on software command.
- Shares the 15-bit DAT address bus and 16-bit DAT data bus with the MMU decoder; it is the writer of the table the MMU reads.
- Gets bus ownership through a req/gnt handshake with the MMU, then writes one 16-bit entry per task page.

---
 rtl/dat_init_sequencer_pkg.sv | 29 ++
 rtl/dat_init_sequencer_cursor.sv | 51 +++++
 rtl/dat_init_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dat_init_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_init_sequencer_pkg.sv
// Shared definitions for the DAT init sequencer: bus widths, the sequencer
// state encoding and the rule for the entry value written per page.
package dat_init_sequencer_pkg;

  localparam int DAT_ADDR_W     = 15;
  localparam int DAT_DATA_W     = 16;
  localparam int PAGES_PER_TASK = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WSETUP,
    WSTROBE,
    VADDR,
    VCMP,
    PAUSE,
    FIN
  } seq_state_e;

  // Entry for a page: high byte zero, low byte is the bank base plus the
  // page number, wrapping modulo 256.
  function automatic logic [DAT_DATA_W-1:0] dat_expect(input logic [7:0] bank_base,
                                                       input logic [7:0] page);
    logic [7:0] lowByte;
    lowByte = bank_base + page;
    return {8'h00, lowByte};
  endfunction

endpackage

// File: rtl/dat_init_sequencer_cursor.sv
// Loadable {task,page} cursor shared by the fill and verify passes. It is one
// bit wider than the DAT address so that reaching task 4095 page 7 is seen by
// the terminal compare rather than by a wrap back to zero.
module dat_cursor #(
  parameter int TASK_BITS = 12,
  parameter int PAGE_BITS = 3
) (
  input  logic                           e,
  input  logic                           reset,
  input  logic                           load_i,
  input  logic                           inc_i,
  input  logic [TASK_BITS-1:0]           loadTask_i,
  input  logic [TASK_BITS-1:0]           lastTask_i,
  output logic [TASK_BITS+PAGE_BITS-1:0] addr_o,
  output logic [TASK_BITS+PAGE_BITS-1:0] addrInc_o,
  output logic                           last_o
);

  localparam int CW = TASK_BITS + PAGE_BITS + 1;

  logic [CW-1:0] cursor_q;
  logic [CW-1:0] cursor_d;
  logic [CW-1:0] cursorInc;
  logic [CW-1:0] lastEntry;

  assign cursorInc = cursor_q + CW'(1);
  assign lastEntry = {1'b0, lastTask_i, {PAGE_BITS{1'b1}}};
  assign addr_o    = cursor_q[CW-2:0];
  assign addrInc_o = cursorInc[CW-2:0];
  assign last_o    = (cursor_q == lastEntry);

  // Load takes priority over increment; otherwise the cursor holds.
  always_comb begin
    cursor_d = cursor_q;
    if (load_i) begin
      cursor_d = {1'b0, loadTask_i, {PAGE_BITS{1'b0}}};
    end else if (inc_i) begin
      cursor_d = cursorInc;
    end
  end

  // Cursor register with synchronous clear.
  always_ff @(posedge e) begin
    if (reset) begin
      cursor_q <= '0;
    end else begin
      cursor_q <= cursor_d;
    end
  end

endmodule

// File: rtl/dat_init_sequencer.sv
// DAT init sequencer: takes the DAT bus from the MMU through req/gnt, writes
// one entry per task page over a task range, then optionally reads the range
// back and compares. A grant drop parks the sequencer and the interrupted
// entry is redone once the grant returns. Every output comes from a register.
module dat_init_sequencer
  import dat_init_sequencer_pkg::*;
#(
  parameter int TASK_BITS = 12,
  parameter int PAGE_BITS = 3,
  parameter bit VERIFY    = 1'b1
) (
  input  logic                  e,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TASK_BITS-1:0]  task_lo,
  input  logic [TASK_BITS-1:0]  task_hi,
  input  logic [7:0]            bank_base,
  output logic                  req,
  input  logic                  gnt,
  output logic [DAT_ADDR_W-1:0] address_dat,
  output logic [DAT_DATA_W-1:0] data_dat_out,
  input  logic [DAT_DATA_W-1:0] data_dat_in,
  output logic                  dat_oe,
  output logic                  _we_dat_l,
  output logic                  _we_dat_h,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DAT_ADDR_W-1:0] err_addr
);

  seq_state_e state_q, state_d;

  logic                  req_q, req_d;
  logic                  datOe_q, datOe_d;
  logic                  weN_q, weN_d;
  logic [DAT_ADDR_W-1:0] addr_q, addr_d;
  logic [DAT_DATA_W-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [DAT_ADDR_W-1:0] errAddr_q, errAddr_d;
  logic                  verifyPhase_q, verifyPhase_d;
  logic [TASK_BITS-1:0]  taskLo_q, taskLo_d;
  logic [TASK_BITS-1:0]  taskHi_q, taskHi_d;
  logic [7:0]            bankBase_q, bankBase_d;

  logic                  curLoad;
  logic                  curInc;
  logic [TASK_BITS-1:0]  curLoadTask;
  logic [DAT_ADDR_W-1:0] curAddr;
  logic [DAT_ADDR_W-1:0] curAddrInc;
  logic                  curLast;

  logic [DAT_DATA_W-1:0] expectCur;
  logic [DAT_DATA_W-1:0] expectInc;

  dat_cursor #(
    .TASK_BITS(TASK_BITS),
    .PAGE_BITS(PAGE_BITS)
  ) uCursor (
    .e          (e),
    .reset      (reset),
    .load_i     (curLoad),
    .inc_i      (curInc),
    .loadTask_i (curLoadTask),
    .lastTask_i (taskHi_q),
    .addr_o     (curAddr),
    .addrInc_o  (curAddrInc),
    .last_o     (curLast)
  );

  assign expectCur = dat_expect(bankBase_q, {{(8-PAGE_BITS){1'b0}}, curAddr[PAGE_BITS-1:0]});
  assign expectInc = dat_expect(bankBase_q, {{(8-PAGE_BITS){1'b0}}, curAddrInc[PAGE_BITS-1:0]});

  assign req          = req_q;
  assign dat_oe       = datOe_q;
  assign _we_dat_l    = weN_q;
  assign _we_dat_h    = weN_q;
  assign address_dat  = addr_q;
  assign data_dat_out = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_addr     = errAddr_q;

  // Next state and next registered outputs; the strobe defaults high so it
  // can only be low for the single cycle spent in WSTROBE.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    datOe_d       = datOe_q;
    weN_d         = 1'b1;
    addr_d        = addr_q;
    data_d        = data_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    errAddr_d     = errAddr_q;
    verifyPhase_d = verifyPhase_q;
    taskLo_d      = taskLo_q;
    taskHi_d      = taskHi_q;
    bankBase_d    = bankBase_q;
    curLoad       = 1'b0;
    curInc        = 1'b0;
    curLoadTask   = taskLo_q;

    unique case (state_q)
      IDLE: begin
      end

      REQ: begin
        if (gnt) begin
          state_d = WSETUP;
          addr_d  = curAddr;
          data_d  = expectCur;
          datOe_d = 1'b1;
        end
      end

      WSETUP: begin
        if (!gnt) begin
          state_d = PAUSE;
          datOe_d = 1'b0;
        end else begin
          state_d = WSTROBE;
          weN_d   = 1'b0;
        end
      end

      WSTROBE: begin
        if (!gnt) begin
          state_d = PAUSE;
          datOe_d = 1'b0;
        end else if (curLast) begin
          if (VERIFY) begin
            state_d       = VADDR;
            curLoad       = 1'b1;
            verifyPhase_d = 1'b1;
            datOe_d       = 1'b0;
            addr_d        = {taskLo_q, {PAGE_BITS{1'b0}}};
          end else begin
            state_d = FIN;
            req_d   = 1'b0;
            datOe_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = ~error_q;
          end
        end else begin
          state_d = WSETUP;
          curInc  = 1'b1;
          addr_d  = curAddrInc;
          data_d  = expectInc;
        end
      end

      VADDR: begin
        if (!gnt) begin
          state_d = PAUSE;
        end else begin
          state_d = VCMP;
        end
      end

      VCMP: begin
        if (!gnt) begin
          state_d = PAUSE;
        end else if (data_dat_in != expectCur) begin
          state_d   = FIN;
          error_d   = 1'b1;
          errAddr_d = curAddr;
          req_d     = 1'b0;
          datOe_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
        end else if (curLast) begin
          state_d = FIN;
          req_d   = 1'b0;
          datOe_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = ~error_q;
        end else begin
          state_d = VADDR;
          curInc  = 1'b1;
          addr_d  = curAddrInc;
        end
      end

      PAUSE: begin
        if (gnt) begin
          addr_d = curAddr;
          if (verifyPhase_q) begin
            state_d = VADDR;
          end else begin
            state_d = WSETUP;
            data_d  = expectCur;
            datOe_d = 1'b1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start && (state_q == IDLE || state_q == FIN)) begin
      if (task_lo > task_hi) begin
        state_d   = IDLE;
        error_d   = 1'b1;
        errAddr_d = '0;
        done_d    = 1'b0;
      end else begin
        state_d       = REQ;
        req_d         = 1'b1;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        error_d       = 1'b0;
        errAddr_d     = '0;
        verifyPhase_d = 1'b0;
        taskLo_d      = task_lo;
        taskHi_d      = task_hi;
        bankBase_d    = bank_base;
        curLoad       = 1'b1;
        curLoadTask   = task_lo;
      end
    end
  end

  // State and output registers; reset abandons any operation in progress.
  always_ff @(posedge e) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      datOe_q       <= 1'b0;
      weN_q         <= 1'b1;
      addr_q        <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      errAddr_q     <= '0;
      verifyPhase_q <= 1'b0;
      taskLo_q      <= '0;
      taskHi_q      <= '0;
      bankBase_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      datOe_q       <= datOe_d;
      weN_q         <= weN_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      errAddr_q     <= errAddr_d;
      verifyPhase_q <= verifyPhase_d;
      taskLo_q      <= taskLo_d;
      taskHi_q      <= taskHi_d;
      bankBase_q    <= bankBase_d;
    end
  end

endmodule

// File: tb/tb_dat_init_sequencer.sv
// Bench for dat_init_sequencer: a behavioural DAT memory answers readback,
// a reference model predicts contents, flags, error address and latency.
module tb_dat_init_sequencer;

  logic        e = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] task_lo;
  logic [11:0] task_hi;
  logic [7:0]  bank_base;
  logic        req;
  logic        gnt;
  logic [14:0] address_dat;
  logic [15:0] data_dat_out;
  logic [15:0] data_dat_in;
  logic        dat_oe;
  logic        _we_dat_l;
  logic        _we_dat_h;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] err_addr;

  logic [15:0] mem [0:32767];
  logic        forceEn;
  logic [14:0] forceAddr;
  logic [15:0] forceVal;

  int testsRun    = 0;
  int testsFailed = 0;

  int writeCount;
  int strobeViolations;
  int finishCycle;
  bit reqSeen;
  bit timedOut;

  localparam logic [63:0] RESET_VEC = {11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 15'd0, 16'd0,
                                       1'b0, 1'b0, 1'b0, 15'd0};

  dat_init_sequencer dut (
    .e            (e),
    .reset        (reset),
    .start        (start),
    .task_lo      (task_lo),
    .task_hi      (task_hi),
    .bank_base    (bank_base),
    .req          (req),
    .gnt          (gnt),
    .address_dat  (address_dat),
    .data_dat_out (data_dat_out),
    .data_dat_in  (data_dat_in),
    .dat_oe       (dat_oe),
    ._we_dat_l    (_we_dat_l),
    ._we_dat_h    (_we_dat_h),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_addr     (err_addr)
  );

  // Free-running E clock.
  always #5 e = ~e;

  // The DAT answers reads from the model memory, with an optional stuck entry.
  assign data_dat_in = (forceEn && address_dat == forceAddr) ? forceVal : mem[address_dat];

  function automatic logic [15:0] modelEntry(input logic [7:0] bank, input int page);
    logic [7:0] lowByte;
    lowByte = bank + 8'(page);
    return {8'h00, lowByte};
  endfunction

  function automatic logic [63:0] outVec();
    return {11'd0, req, dat_oe, _we_dat_l, _we_dat_h, address_dat, data_dat_out,
            busy, done, error, err_addr};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic runOp(input int lo, input int hi, input logic [7:0] bank,
                       input int grantWait, input bit stallEn,
                       input logic [14:0] stallAddr, input bit pokeStart);
    int cyc;
    int stallLeft;
    bit stallDone;
    bit gntAtEdge;
    for (int a = 0; a < 32768; a++) mem[a] = 16'hDEAD;
    writeCount = 0;
    strobeViolations = 0;
    reqSeen = 0;
    timedOut = 0;
    finishCycle = -1;
    stallLeft = 0;
    stallDone = 0;
    task_lo = 12'(lo);
    task_hi = 12'(hi);
    bank_base = bank;
    gnt = (grantWait == 0);
    start = 1'b1;
    cyc = 0;
    while (1) begin
      @(posedge e);
      gntAtEdge = gnt;
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == grantWait + 1) gnt = 1'b1;
      if (req) reqSeen = 1;
      if (!_we_dat_l || !_we_dat_h) begin
        if (!gntAtEdge || !dat_oe || (_we_dat_l != _we_dat_h)) strobeViolations++;
        mem[address_dat] = data_dat_out;
        writeCount++;
      end
      if (stallEn && !stallDone && !_we_dat_l && address_dat == stallAddr) begin
        gnt = 1'b0;
        stallLeft = 5;
        stallDone = 1;
      end else if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) gnt = 1'b1;
      end
      if (pokeStart && cyc == 12) begin
        start = 1'b1;
        task_lo = 12'(lo + 100);
        bank_base = ~bank;
      end
      if (pokeStart && cyc == 13) begin
        start = 1'b0;
        task_lo = 12'(lo);
        bank_base = bank;
      end
      if (cyc >= 1 && !busy) begin
        finishCycle = cyc;
        break;
      end
      if (cyc >= 4000) begin
        timedOut = 1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input int lo, input int hi,
                               input logic [7:0] bank, input int grantWait,
                               input bit stallEn, input bit pokeStart);
    bit valid;
    bit mismatch;
    int n;
    int firstAddr;
    int lastAddr;
    int k;
    int bad;
    int dirty;
    int expLatency;
    valid = (lo <= hi);
    n = valid ? hi - lo + 1 : 0;
    firstAddr = lo * 8;
    lastAddr = hi * 8 + 7;
    runOp(lo, hi, bank, grantWait, stallEn, 15'(firstAddr + 5), pokeStart);
    mismatch = 0;
    k = 0;
    if (valid && forceEn && int'(forceAddr) >= firstAddr && int'(forceAddr) <= lastAddr &&
        forceVal != modelEntry(bank, int'(forceAddr) % 8)) begin
      mismatch = 1;
      k = int'(forceAddr) - firstAddr;
    end
    if (!valid) expLatency = 1;
    else if (mismatch) expLatency = 2 + grantWait + 16 * n + 2 * (k + 1);
    else expLatency = 2 + grantWait + 32 * n;
    checkOutput({name, ":timeout"}, 64'(timedOut), 64'(0));
    checkOutput({name, ":done"}, 64'(done), 64'(valid && !mismatch));
    checkOutput({name, ":error"}, 64'(error), 64'(!valid || mismatch));
    checkOutput({name, ":err_addr"}, 64'(err_addr), mismatch ? 64'(forceAddr) : 64'(0));
    checkOutput({name, ":reqAtEnd"}, 64'(req), 64'(0));
    checkOutput({name, ":datOeAtEnd"}, 64'(dat_oe), 64'(0));
    checkOutput({name, ":reqSeen"}, 64'(reqSeen), 64'(valid));
    checkOutput({name, ":writes"}, 64'(writeCount),
                64'(valid ? 8 * n + (stallEn ? 1 : 0) : 0));
    checkOutput({name, ":strobeRules"}, 64'(strobeViolations), 64'(0));
    if (!stallEn) checkOutput({name, ":latency"}, 64'(finishCycle), 64'(expLatency));
    bad = 0;
    dirty = 0;
    for (int a = 0; a < 32768; a++) begin
      if (valid && a >= firstAddr && a <= lastAddr) begin
        if (mem[a] != modelEntry(bank, a % 8)) bad++;
      end else if (mem[a] != 16'hDEAD) begin
        dirty++;
      end
    end
    checkOutput({name, ":memInRange"}, 64'(bad), 64'(0));
    checkOutput({name, ":memOutside"}, 64'(dirty), 64'(0));
    if (timedOut) begin
      reset = 1'b1;
      @(posedge e);
      #1 reset = 1'b0;
    end
    gnt = 1'b1;
    repeat (2) @(posedge e);
    #1;
  endtask

  initial begin
    int lo;
    int hi;
    int n;
    logic [7:0] bank;
    forceEn = 1'b0;
    forceAddr = '0;
    forceVal = '0;
    reset = 1'b1;
    start = 1'b0;
    gnt = 1'b1;
    task_lo = '0;
    task_hi = '0;
    bank_base = '0;
    repeat (2) @(posedge e);
    #1;
    checkOutput("resetState", outVec(), RESET_VEC);
    reset = 1'b0;
    @(posedge e);
    #1;

    applyStimulus("basic", 0, 0, 8'h00, 0, 0, 0);
    applyStimulus("rangeOffset", 3, 4, 8'hFC, 0, 0, 0);

    forceEn = 1'b1;
    forceAddr = 15'h01A;
    forceVal = 16'h0055;
    applyStimulus("mismatch", 3, 4, 8'hFC, 0, 0, 0);
    forceEn = 1'b0;

    applyStimulus("grantStall", 2, 2, 8'($urandom), 0, 1, 0);
    applyStimulus("topTask", 4095, 4095, 8'($urandom), 0, 0, 0);
    applyStimulus("badRange", 5, 4, 8'h33, 0, 0, 0);
    applyStimulus("startWhileBusy", 10, 11, 8'($urandom), 0, 0, 1);

    for (int r = 0; r < 4; r++) begin
      lo = int'($urandom_range(0, 4090));
      hi = lo + int'($urandom_range(0, 2));
      applyStimulus($sformatf("random%0d", r), lo, hi, 8'($urandom),
                    int'($urandom_range(0, 3)), 0, 0);
    end

    lo = int'($urandom_range(0, 4090));
    hi = lo + int'($urandom_range(0, 2));
    n = hi - lo + 1;
    bank = 8'($urandom);
    forceEn = 1'b1;
    forceAddr = 15'(lo * 8 + int'($urandom_range(0, 8 * n - 1)));
    forceVal = modelEntry(bank, int'(forceAddr) % 8) ^ 16'h8000;
    applyStimulus("randomMismatch", lo, hi, bank, int'($urandom_range(0, 3)), 0, 0);
    forceEn = 1'b0;

    task_lo = 12'd7;
    task_hi = 12'd9;
    bank_base = 8'h11;
    gnt = 1'b1;
    start = 1'b1;
    @(posedge e);
    #1 start = 1'b0;
    repeat (9) @(posedge e);
    #1;
    checkOutput("midWriteBusy", 64'(busy), 64'(1));
    reset = 1'b1;
    start = 1'b1;
    @(posedge e);
    #1;
    checkOutput("midWriteReset", outVec(), RESET_VEC);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge e);
    #1;
    checkOutput("resetWinsOverStart", 64'({busy, req}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
